// File: rtl/console_pkg.sv
// Shared constants and helpers for the console FIFO controller and its FIFOs.
package console_pkg;

    typedef enum logic [1:0] {
        RegSetup = 2'd0,
        RegFifo  = 2'd1,
        RegRx    = 2'd2,
        RegTx    = 2'd3
    } reg_addr_e;

    localparam int unsigned BitEmpty = 8;
    localparam int unsigned BitTxStb = 8;
    localparam int unsigned BitOvf   = 12;
    localparam int unsigned BitFlush = 12;
    localparam int unsigned BitTmo   = 13;
    localparam int unsigned BitFull  = 13;

    localparam logic [7:0]  DefThresh  = 8'd1;
    localparam logic [15:0] DefTimeout = 16'd0;

    // Thresholds of 0 behave as 1; anything beyond the FIFO depth saturates at the depth.
    function automatic logic [7:0] clamp_thresh(input logic [7:0] val, input logic [8:0] depth);
        if (val == 8'd0) begin
            return 8'd1;
        end
        if ({1'b0, val} > depth) begin
            return depth[7:0];
        end
        return val;
    endfunction

endpackage

// File: rtl/console_sfifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is only taken alongside a pop.
module console_sfifo #(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [BW-1:0]     i_data,
    output logic [BW-1:0]     o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic [LGFLEN:0]   o_fill
);

    localparam int unsigned       Depth     = 1 << LGFLEN;
    localparam logic [LGFLEN:0]   DepthFill = (LGFLEN + 1)'(Depth);
    localparam logic [LGFLEN:0]   FillOne   = 1;
    localparam logic [LGFLEN-1:0] PtrOne    = 1;

    logic [BW-1:0]     mem_q [Depth];
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   fill_q, fill_d;
    logic              do_push, do_pop;

    assign o_empty = (fill_q == '0);
    assign o_full  = (fill_q == DepthFill);
    assign o_fill  = fill_q;
    assign o_head  = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored, so a simultaneous push still lands.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (do_push && !do_pop) begin
                fill_d = fill_q + FillOne;
            end else if (do_pop && !do_push) begin
                fill_d = fill_q - FillOne;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/console_fifo_ctrl.sv
// Console channel controller: RX/TX FIFOs behind a 4-register pipelined Wishbone slave,
// with programmable thresholds, RX idle timeout and sticky overflow flags.
module console_fifo_ctrl
    import console_pkg::*;
#(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [1:0]    i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [31:0]   o_wb_data,
    output logic          o_tx_stb,
    output logic [BW-1:0] o_tx_data,
    input  logic          i_tx_busy,
    input  logic          i_rx_stb,
    input  logic [BW-1:0] i_rx_data,
    output logic          o_rx_int,
    output logic          o_tx_int
);

    localparam int unsigned     Depth     = 1 << LGFLEN;
    localparam logic [8:0]      DepthW    = 9'(Depth);
    localparam logic [LGFLEN:0] DepthFill = (LGFLEN + 1)'(Depth);

    // Bus decode
    reg_addr_e addr;
    logic      wb_req, wb_wr, wb_rd;
    logic      setup_wr, rx_rd, rx_clr, tx_clr, tx_wr;
    logic      rx_flush, tx_flush;

    assign addr     = reg_addr_e'(i_wb_addr);
    assign wb_req   = i_wb_stb && i_wb_cyc;
    assign wb_wr    = wb_req && i_wb_we;
    assign wb_rd    = wb_req && !i_wb_we;
    assign setup_wr = wb_wr && (addr == RegSetup);
    assign rx_rd    = wb_rd && (addr == RegRx);
    assign rx_clr   = wb_wr && (addr == RegRx) && i_wb_data[BitFlush];
    assign tx_clr   = wb_wr && (addr == RegTx) && i_wb_data[BitFlush];
    assign tx_wr    = wb_wr && (addr == RegTx) && !i_wb_data[BitFlush] && i_wb_sel[0];
    assign rx_flush = setup_wr || rx_clr;
    assign tx_flush = setup_wr || tx_clr;

    // FIFOs
    logic [BW-1:0]   rx_head, tx_head;
    logic            rx_empty, rx_full, tx_empty, tx_full, tx_pop;
    logic [LGFLEN:0] rx_fill, tx_fill, tx_free;

    assign tx_pop  = !tx_empty && !i_tx_busy;
    assign tx_free = DepthFill - tx_fill;

    console_sfifo #(
        .BW     (BW),
        .LGFLEN (LGFLEN)
    ) u_rx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (i_rx_stb),
        .i_pop     (rx_rd),
        .i_flush   (rx_flush),
        .i_data    (i_rx_data),
        .o_head    (rx_head),
        .o_empty   (rx_empty),
        .o_full    (rx_full),
        .o_fill    (rx_fill)
    );

    console_sfifo #(
        .BW     (BW),
        .LGFLEN (LGFLEN)
    ) u_tx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (tx_wr),
        .i_pop     (tx_pop),
        .i_flush   (tx_flush),
        .i_data    (i_wb_data[BW-1:0]),
        .o_head    (tx_head),
        .o_empty   (tx_empty),
        .o_full    (tx_full),
        .o_fill    (tx_fill)
    );

    assign o_tx_stb  = !tx_empty;
    assign o_tx_data = tx_head;

    // Setup, flags and idle timer
    logic [7:0]  rx_thresh_q, rx_thresh_d;
    logic [7:0]  tx_thresh_q, tx_thresh_d;
    logic [15:0] timeout_q, timeout_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        rx_ovf_q, rx_ovf_d;
    logic        rx_tmo_q, rx_tmo_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_drop, tx_drop, tmo_restart, tmo_hit;

    // A full RX FIFO still accepts a character when a read pops in the same cycle.
    assign rx_drop     = i_rx_stb && rx_full && !rx_rd && !rx_flush;
    assign tx_drop     = tx_wr && tx_full && !tx_pop;
    assign tmo_restart = i_rx_stb || rx_rd || rx_empty;
    assign tmo_hit     = !tmo_restart && (timeout_q != '0) && (tmo_cnt_q == timeout_q);

    always_comb begin
        rx_thresh_d = rx_thresh_q;
        tx_thresh_d = tx_thresh_q;
        timeout_d   = timeout_q;
        if (setup_wr) begin
            if (i_wb_sel[0]) rx_thresh_d = clamp_thresh(i_wb_data[7:0], DepthW);
            if (i_wb_sel[1]) tx_thresh_d = clamp_thresh(i_wb_data[15:8], DepthW);
            if (i_wb_sel[2]) timeout_d[7:0] = i_wb_data[23:16];
            if (i_wb_sel[3]) timeout_d[15:8] = i_wb_data[31:24];
        end
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_restart) begin
            tmo_cnt_d = '0;
        end else if (!tmo_hit && (tmo_cnt_q != '1)) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_comb begin
        rx_ovf_d = rx_ovf_q;
        rx_tmo_d = rx_tmo_q;
        tx_ovf_d = tx_ovf_q;
        if (tmo_hit) rx_tmo_d = 1'b1;
        if (rx_rd) begin
            rx_tmo_d = 1'b0;
            if (!rx_empty) rx_ovf_d = 1'b0;
        end
        if (rx_drop) rx_ovf_d = 1'b1;
        if (tx_drop) tx_ovf_d = 1'b1;
        if (rx_flush) begin
            rx_ovf_d = 1'b0;
            rx_tmo_d = 1'b0;
        end
        if (tx_flush) tx_ovf_d = 1'b0;
    end

    // Read mux, sampled at the strobe edge so RXREG sees the head before its pop.
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        unique case (addr)
            RegSetup: rd_data = {timeout_q, tx_thresh_q, rx_thresh_q};
            RegFifo: begin
                rd_data[31:28] = 4'(LGFLEN);
                rd_data[27:16] = 12'(tx_free);
                rd_data[11:0]  = 12'(rx_fill);
            end
            RegRx: begin
                if (!rx_empty) rd_data[BW-1:0] = rx_head;
                rd_data[BitEmpty] = rx_empty;
                rd_data[BitOvf]   = rx_ovf_q;
                rd_data[BitTmo]   = rx_tmo_q;
            end
            RegTx: begin
                if (!tx_empty) rd_data[BW-1:0] = tx_head;
                rd_data[BitTxStb] = !tx_empty;
                rd_data[BitOvf]   = tx_ovf_q;
                rd_data[BitFull]  = tx_full;
            end
            default: rd_data = '0;
        endcase
    end

    // Three-stage ack pipeline; dropping cyc kills anything in flight.
    logic        req1_q, req1_d, req2_q, req2_d, ack_q, ack_d;
    logic [31:0] data1_q, data1_d, data2_q, data2_d, wb_data_q, wb_data_d;
    logic        rx_int_q, rx_int_d, tx_int_q, tx_int_d;

    always_comb begin
        req1_d    = wb_req;
        data1_d   = wb_rd ? rd_data : '0;
        req2_d    = req1_q && i_wb_cyc;
        data2_d   = data1_q;
        ack_d     = req2_q && i_wb_cyc;
        wb_data_d = data2_q;
        rx_int_d  = (8'(rx_fill) >= rx_thresh_q) || rx_tmo_q;
        tx_int_d  = (8'(tx_free) >= tx_thresh_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rx_thresh_q <= DefThresh;
            tx_thresh_q <= DefThresh;
            timeout_q   <= DefTimeout;
            tmo_cnt_q   <= '0;
            rx_ovf_q    <= 1'b0;
            rx_tmo_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            req1_q      <= 1'b0;
            req2_q      <= 1'b0;
            ack_q       <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            wb_data_q   <= '0;
            rx_int_q    <= 1'b0;
            tx_int_q    <= 1'b1;
        end else begin
            rx_thresh_q <= rx_thresh_d;
            tx_thresh_q <= tx_thresh_d;
            timeout_q   <= timeout_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rx_ovf_q    <= rx_ovf_d;
            rx_tmo_q    <= rx_tmo_d;
            tx_ovf_q    <= tx_ovf_d;
            req1_q      <= req1_d;
            req2_q      <= req2_d;
            ack_q       <= ack_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            wb_data_q   <= wb_data_d;
            rx_int_q    <= rx_int_d;
            tx_int_q    <= tx_int_d;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = wb_data_q;
    assign o_rx_int   = rx_int_q;
    assign o_tx_int   = tx_int_q;

endmodule
